// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the single-clock FIFO family.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH flop storage: one synchronous write port, one asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clka,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; pointers and count define what is valid.
  always_ff @(posedge clka) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with selectable registered or fall-through read,
// fill count, programmable almost flags and sticky overflow/underflow.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int         WIDTH     = 8,
  parameter int         DEPTH     = 16,
  parameter fifo_mode_e MODE      = FIFO_STD,
  parameter int         AF_THRESH = DEPTH - 2,
  parameter int         AE_THRESH = 1
) (
  input  logic                     clka,
  input  logic                     reset_clka,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din_clka,
  input  logic                     rd,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         dout_clka,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              wr_acc;
  logic              rd_acc;
  logic [WIDTH-1:0]  mem_rd_data;

  assign wr_acc = wr && !full;
  assign rd_acc = rd && !empty;

  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clka    (clka),
    .we      (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (din_clka),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  // DEPTH is a power of two, so pointer wrap is plain modulo overflow.
  always_ff @(posedge clka or posedge reset_clka) begin
    if (reset_clka) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clka or posedge reset_clka) begin
    if (reset_clka) begin
      count_q <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count        = count_q;
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);

  // A rejected request in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clka or posedge reset_clka) begin
    if (reset_clka) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full)       overflow <= 1'b1;
      else if (clr_err)     overflow <= 1'b0;
      if (rd && empty)      underflow <= 1'b1;
      else if (clr_err)     underflow <= 1'b0;
    end
  end

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      // Storage is unreset, so the empty-time value is forced to a known constant.
      assign dout_clka = empty ? '0 : mem_rd_data;
    end else begin : g_std
      always_ff @(posedge clka or posedge reset_clka) begin
        if (reset_clka) begin
          dout_clka <= '0;
        end else if (rd_acc) begin
          dout_clka <= mem_rd_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench: three FIFO configurations on shared stimulus, compared every
// cycle against a queue-based reference, plus table vectors and directed corner cases.
module tb_fifo_sync_param;
  import fifo_pkg::*;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic       reset_clka;
  logic       wr, rd, clr_err;
  logic [7:0] din;

  logic [7:0] dout_a  [3];
  logic       full_a  [3];
  logic       empty_a [3];
  logic       af_a    [3];
  logic       ae_a    [3];
  logic       ovf_a   [3];
  logic       unf_a   [3];
  logic [3:0] cnt8_s, cnt8_f;
  logic [2:0] cnt4;

  int checks = 0;
  int errors = 0;

  fifo_sync_param #(.WIDTH(8), .DEPTH(8), .MODE(FIFO_STD), .AF_THRESH(6), .AE_THRESH(1)) u_std8 (
    .clka(clka), .reset_clka(reset_clka), .wr(wr), .din_clka(din), .rd(rd), .clr_err(clr_err),
    .dout_clka(dout_a[0]), .full(full_a[0]), .empty(empty_a[0]), .almost_full(af_a[0]),
    .almost_empty(ae_a[0]), .count(cnt8_s), .overflow(ovf_a[0]), .underflow(unf_a[0]));

  fifo_sync_param #(.WIDTH(8), .DEPTH(8), .MODE(FIFO_FWFT), .AF_THRESH(6), .AE_THRESH(1)) u_fwft8 (
    .clka(clka), .reset_clka(reset_clka), .wr(wr), .din_clka(din), .rd(rd), .clr_err(clr_err),
    .dout_clka(dout_a[1]), .full(full_a[1]), .empty(empty_a[1]), .almost_full(af_a[1]),
    .almost_empty(ae_a[1]), .count(cnt8_f), .overflow(ovf_a[1]), .underflow(unf_a[1]));

  fifo_sync_param #(.WIDTH(8), .DEPTH(4), .MODE(FIFO_STD), .AF_THRESH(3), .AE_THRESH(1)) u_std4 (
    .clka(clka), .reset_clka(reset_clka), .wr(wr), .din_clka(din), .rd(rd), .clr_err(clr_err),
    .dout_clka(dout_a[2]), .full(full_a[2]), .empty(empty_a[2]), .almost_full(af_a[2]),
    .almost_empty(ae_a[2]), .count(cnt4), .overflow(ovf_a[2]), .underflow(unf_a[2]));

  // ---------------- reference model ----------------
  logic [7:0] q0[$], q1[$], q2[$];
  logic [7:0] m_dout [3];
  bit         m_ovf  [3];
  bit         m_unf  [3];

  function automatic int dep(int i);   return (i == 2) ? 4 : 8; endfunction
  function automatic int afth(int i);  return (i == 2) ? 3 : 6; endfunction
  function automatic int aeth(int i);  return 1;                endfunction
  function automatic bit is_fwft(int i); return (i == 1);       endfunction

  function automatic int qsize(int i);
    if (i == 0) return q0.size();
    if (i == 1) return q1.size();
    return q2.size();
  endfunction

  function automatic logic [7:0] qfront(int i);
    if (i == 0) return q0[0];
    if (i == 1) return q1[0];
    return q2[0];
  endfunction

  task automatic qpush(int i, logic [7:0] d);
    if (i == 0) q0.push_back(d);
    else if (i == 1) q1.push_back(d);
    else q2.push_back(d);
  endtask

  task automatic qpop(int i, output logic [7:0] d);
    if (i == 0) d = q0.pop_front();
    else if (i == 1) d = q1.pop_front();
    else d = q2.pop_front();
  endtask

  function automatic logic [31:0] act_cnt(int i);
    if (i == 0) return 32'(cnt8_s);
    if (i == 1) return 32'(cnt8_f);
    return 32'(cnt4);
  endfunction

  task automatic model_reset();
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) begin
      m_dout[i] = 8'h00;
      m_ovf[i]  = 1'b0;
      m_unf[i]  = 1'b0;
    end
  endtask

  task automatic model_step(bit w, logic [7:0] d, bit r, bit c);
    for (int i = 0; i < 3; i++) begin
      int         sz;
      bit         fl, em;
      logic [7:0] v;
      sz = qsize(i);
      fl = (sz == dep(i));
      em = (sz == 0);
      if (r && !em) begin
        qpop(i, v);
        if (!is_fwft(i)) m_dout[i] = v;
      end
      if (w && !fl) qpush(i, d);
      if (w && fl) m_ovf[i] = 1'b1; else if (c) m_ovf[i] = 1'b0;
      if (r && em) m_unf[i] = 1'b1; else if (c) m_unf[i] = 1'b0;
    end
  endtask

  task automatic check(string name, int inst, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[inst %0d] t=%0t: got %0h, expected %0h", name, inst, $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int sz;
      sz = qsize(i);
      check("count",        i, act_cnt(i),          32'(sz));
      check("full",         i, 32'(full_a[i]),      32'(sz == dep(i)));
      check("empty",        i, 32'(empty_a[i]),     32'(sz == 0));
      check("almost_full",  i, 32'(af_a[i]),        32'(sz >= afth(i)));
      check("almost_empty", i, 32'(ae_a[i]),        32'(sz <= aeth(i)));
      check("overflow",     i, 32'(ovf_a[i]),       32'(m_ovf[i]));
      check("underflow",    i, 32'(unf_a[i]),       32'(m_unf[i]));
      if (is_fwft(i)) begin
        if (sz > 0) check("dout_fwft", i, 32'(dout_a[i]), 32'(qfront(i)));
        else        check("dout_fwft_known", i, 32'($isunknown(dout_a[i])), 32'(0));
      end else begin
        check("dout_std", i, 32'(dout_a[i]), 32'(m_dout[i]));
      end
    end
  endtask

  // One clock of stimulus: drive after the falling edge, check at the next falling edge.
  task automatic cycle(bit w, logic [7:0] d, bit r, bit c);
    wr = w; din = d; rd = r; clr_err = c;
    @(posedge clka);
    model_step(w, d, r, c);
    @(negedge clka);
    check_all();
  endtask

  // Reset asserted between edges; outputs must respond before any clock edge.
  task automatic async_reset();
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0; din = 8'h00;
    #2 reset_clka = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge clka);
    reset_clka = 1'b0;
  endtask

  // ---------------- table vectors for DEPTH=8 STD ----------------
  typedef struct {
    bit         wr;
    logic [7:0] din;
    bit         rd;
    int         cnt;
    bit         full;
    bit         af;
    bit         ovf;
    bit         unf;
    logic [7:0] dout;
  } vec_t;

  vec_t tv[$];

  function automatic void add_vec(bit w, logic [7:0] d, bit r, int cnt, bit fl, bit af,
                                  bit ovf, bit unf, logic [7:0] dout);
    vec_t v;
    v.wr = w; v.din = d; v.rd = r; v.cnt = cnt; v.full = fl; v.af = af;
    v.ovf = ovf; v.unf = unf; v.dout = dout;
    tv.push_back(v);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 1; k <= 8; k++) add_vec(1, 8'(k), 0, k, k == 8, k >= 6, 0, 0, 8'h00);
    add_vec(1, 8'h09, 0, 8, 1, 1, 1, 0, 8'h00);
    for (int k = 1; k <= 8; k++) add_vec(0, 8'h00, 1, 8 - k, 0, (8 - k) >= 6, 1, 0, 8'(k));
    add_vec(0, 8'h00, 1, 0, 0, 0, 1, 1, 8'h08);

    reset_clka = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; din = 8'h00;
    model_reset();
    @(negedge clka); @(negedge clka);
    check_all();
    reset_clka = 1'b0;

    // Async reset mid-stream with five words held
    for (int k = 0; k < 5; k++) cycle(1, 8'h40 + 8'(k), 0, 0);
    check("pre_reset_count", 0, 32'(cnt8_s), 32'd5);
    async_reset();
    check("reset_count", 0, 32'(cnt8_s), 32'd0);
    check("reset_empty", 0, 32'(empty_a[0]), 32'd1);

    // Fill/drain table
    async_reset();
    foreach (tv[n]) begin
      cycle(tv[n].wr, tv[n].din, tv[n].rd, 1'b0);
      check("tv_count",     n, 32'(cnt8_s),    32'(tv[n].cnt));
      check("tv_full",      n, 32'(full_a[0]), 32'(tv[n].full));
      check("tv_af",        n, 32'(af_a[0]),   32'(tv[n].af));
      check("tv_overflow",  n, 32'(ovf_a[0]),  32'(tv[n].ovf));
      check("tv_underflow", n, 32'(unf_a[0]),  32'(tv[n].unf));
      check("tv_dout",      n, 32'(dout_a[0]), 32'(tv[n].dout));
    end

    // FWFT first word visible in the cycle empty falls
    async_reset();
    cycle(1, 8'hA5, 0, 0);
    check("fwft_empty", 1, 32'(empty_a[1]), 32'd0);
    check("fwft_dout",  1, 32'(dout_a[1]),  32'hA5);
    cycle(0, 8'h00, 1, 0);
    check("fwft_empty_after_rd", 1, 32'(empty_a[1]), 32'd1);

    // Wrap-around at one word of occupancy
    async_reset();
    cycle(1, 8'h10, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cycle(1, 8'h11 + 8'(k), 1, 0);
      check("wrap_count", 2, 32'(cnt4), 32'd1);
      check("wrap_dout",  2, 32'(dout_a[2]), 32'(8'h10 + 8'(k)));
    end

    // Full plus simultaneous wr/rd
    async_reset();
    for (int k = 0; k < 4; k++) cycle(1, 8'h21 + 8'(k), 0, 0);
    cycle(1, 8'h25, 1, 0);
    check("full_rw_count", 2, 32'(cnt4), 32'd3);
    check("full_rw_ovf",   2, 32'(ovf_a[2]), 32'd1);
    check("full_rw_dout",  2, 32'(dout_a[2]), 32'h21);
    cycle(0, 8'h00, 0, 1);
    check("clr_ovf", 2, 32'(ovf_a[2]), 32'd0);

    // Set wins over clear
    async_reset();
    cycle(0, 8'h00, 1, 0);
    check("unf_set", 0, 32'(unf_a[0]), 32'd1);
    cycle(0, 8'h00, 1, 1);
    check("unf_set_wins", 0, 32'(unf_a[0]), 32'd1);
    cycle(0, 8'h00, 0, 1);
    check("unf_clr", 0, 32'(unf_a[0]), 32'd0);

    // Randomized traffic with drifting bias to visit full and empty
    async_reset();
    for (int n = 0; n < 3000; n++) begin
      int wb, rb;
      bit w, r, c;
      wb = ((n / 150) % 3 == 0) ? 80 : ((n / 150) % 3 == 1) ? 25 : 55;
      rb = 100 - wb;
      w = ($urandom_range(99, 0) < wb);
      r = ($urandom_range(99, 0) < rb);
      c = ($urandom_range(19, 0) == 0);
      if ($urandom_range(599, 0) == 0) async_reset();
      cycle(w, 8'($urandom), r, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
